// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divider port bundle.
//
// Handshake: the pipeline presents a divide by holding `start` high with a
// div-class `alucontrol`. The unit answers with `stall` (combinational) until
// `ready` pulses for exactly one cycle. During that cycle `result` is valid and
// `stall` is low, so the pipeline advances. `annul` aborts at any time. The
// operands are sampled only in the accept cycle.
interface div_unit_if;
   logic [7:0]  alucontrol;
   logic        start;
   logic        annul;
   logic [31:0] a;
   logic [31:0] b;
   logic [63:0] result;
   logic        ready;
   logic        stall;
   logic [1:0]  dbg_state;

   modport master (
      output alucontrol, start, annul, a, b,
      input  result, ready, stall, dbg_state
   );

   modport slave (
      input  alucontrol, start, annul, a, b,
      output result, ready, stall, dbg_state
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider (DIV / DIVU).
// It returns {hi = remainder, lo = quotient} with a one-cycle ready pulse.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle.
// Without the macro, a zero divisor runs the full 33-cycle path.
module div_unit (
   input logic       clk,
   input logic       resetn,
   div_unit_if.slave bus
);
   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ON    = 2'd1,
      S_DZERO = 2'd2,
      S_END   = 2'd3
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [64:0] work;      // {rem[32:0], quo[31:0]}
   logic [31:0] dvsr;      // divisor magnitude
   logic        a_neg;
   logic        b_neg;
   logic        b_zero;
   logic [63:0] result_r;
   logic        ready_r;

   logic        is_div;
   logic        signed_op;
   logic [31:0] a_abs;
   logic [31:0] b_abs;
   logic [64:0] shifted;
   logic [32:0] trial;
   logic [64:0] step_nxt;
   logic [31:0] quo_fin;
   logic [31:0] rem_fin;

   // Decode, operand magnitudes and one restoring step.
   always_comb begin
      is_div    = (bus.alucontrol == EXE_DIV_OP) || (bus.alucontrol == EXE_DIVU_OP);
      signed_op = (bus.alucontrol == EXE_DIV_OP);
      a_abs     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
      b_abs     = (signed_op && bus.b[31]) ? -bus.b : bus.b;
      shifted   = work << 1;
      trial     = shifted[64:32] - {1'b0, dvsr};
      // A negative trial means the divisor does not fit. Keep the shifted value.
      step_nxt  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
      quo_fin   = (a_neg ^ b_neg) ? -step_nxt[31:0] : step_nxt[31:0];
      rem_fin   = a_neg ? -step_nxt[63:32] : step_nxt[63:32];
   end

   // Control FSM and datapath. The final step's signed fix-up is registered
   // on the edge that enters END, so ready is visible during the END cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         cnt      <= 6'd0;
         work     <= 65'd0;
         dvsr     <= 32'd0;
         a_neg    <= 1'b0;
         b_neg    <= 1'b0;
         b_zero   <= 1'b0;
         result_r <= 64'd0;
         ready_r  <= 1'b0;
      end else if (bus.annul) begin
         state   <= S_IDLE;
         ready_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready_r <= 1'b0;
               if (bus.start && is_div) begin
                  work   <= {33'd0, a_abs};
                  dvsr   <= b_abs;
                  a_neg  <= signed_op & bus.a[31];
                  b_neg  <= signed_op & bus.b[31];
                  b_zero <= (bus.b == 32'd0);
                  cnt    <= 6'd0;
`ifdef DIV_ZERO_FAST_EN
                  if (bus.b == 32'd0) begin
                     result_r <= 64'd0;
                     ready_r  <= 1'b1;
                     state    <= S_DZERO;
                  end else begin
                     state <= S_ON;
                  end
`else
                  state <= S_ON;
`endif
               end
            end
            S_ON: begin
               work <= step_nxt;
               cnt  <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  result_r <= b_zero ? 64'd0 : {rem_fin, quo_fin};
                  ready_r  <= 1'b1;
                  state    <= S_END;
               end
            end
`ifdef DIV_ZERO_FAST_EN
            S_DZERO: begin
               ready_r <= 1'b0;
               state   <= S_IDLE;
            end
`endif
            S_END: begin
               ready_r <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               ready_r <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

   // Hold the pipeline from acceptance until ready appears. Annul releases it at once.
   always_comb begin
      bus.stall     = bus.start & is_div & ~ready_r & ~bus.annul;
      bus.result    = result_r;
      bus.ready     = ready_r;
      bus.dbg_state = state;
   end
endmodule
